// File: rtl/scan_reg_bank.sv
// Multi-chain mux-D scan register bank with a functional load, a shift counter
// that pulses on every full WIDTH-bit shift, and an optional shadow stage on Q.

module scan_chain #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             SE,
  input  logic             EN,
  input  logic             SI,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] C
);

  always_ff @(posedge CLK) begin
    if (!RN)     C <= '0;
    else if (SE) C <= {C[WIDTH-2:0], SI};
    else if (EN) C <= D;
  end

endmodule

module scan_reg_bank #(
  parameter int WIDTH  = 8,
  parameter int CHAINS = 1,
  parameter int SHADOW = 1,
  localparam int N     = WIDTH * CHAINS,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              SE,
  input  logic [CHAINS-1:0] SI,
  output logic [CHAINS-1:0] SO,
  input  logic [N-1:0]      D,
  input  logic              EN,
  input  logic              UPD,
  output logic [N-1:0]      Q,
  output logic [CW-1:0]     SHIFT_CNT,
  output logic              SHIFT_DONE
);

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  logic [CHAINS-1:0][WIDTH-1:0] cap;
  logic [N-1:0]                 c_q;
  logic [N-1:0]                 s_q;
  logic                         state;
  logic [CW-1:0]                cnt;
  logic                         done;

  for (genvar c = 0; c < CHAINS; c++) begin : g_chain
    scan_chain #(.WIDTH(WIDTH)) u_chain (
      .CLK (CLK),
      .RN  (RN),
      .SE  (SE),
      .EN  (EN),
      .SI  (SI[c]),
      .D   (D[c*WIDTH +: WIDTH]),
      .C   (cap[c])
    );
    // SO comes straight off the last flop so the scan path has no mux after it.
    assign SO[c] = cap[c][WIDTH-1];
  end

  assign c_q = cap;

  // The shadow copies the pre-edge capture value, so EN+UPD loads old C into S.
  always_ff @(posedge CLK) begin
    if (!RN)              s_q <= '0;
    else if (!SE && UPD)  s_q <= c_q;
  end

  assign Q = (SHADOW != 0) ? s_q : c_q;

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (SE) begin
            state <= SHIFT;
            cnt   <= CW'(1);
            done  <= 1'b0;
          end
        end
        SHIFT: begin
          if (!SE) begin
            // Abandoning a partial shift never reports completion.
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
          end else if (cnt == CW'(WIDTH-1)) begin
            cnt   <= '0;
            done  <= 1'b1;
          end else begin
            cnt   <= cnt + CW'(1);
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign SHIFT_CNT  = cnt;
  assign SHIFT_DONE = done;

endmodule
